inst_encoder: RTL
=================

Name: inst_encoder

Overview:
Assembles RV32I field bundles (opcode, func3, func7 bit, register indices, immediate, format) into 32-bit instruction words. It is the inverse of the instruction field decoder. Encoded words are buffered in a small FIFO and streamed out, each tagged with a sequential byte address. The block feeds the instruction-memory preload path and self-check benches: words it emits are loaded into IMEM and later decoded by the CPU.

Parameters:
DEPTH, 4, FIFO entries; power of two, >=2
BASE_ADDR, 32'h0000_0000, address tagged on first emitted word after reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  field bundle valid
in_ready  output  1  block can accept bundle (FIFO not full)
in_fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
in_opcode  input  5  instruction bits [6:2]; bits [1:0] forced 2'b11
in_func3  input  3  bits [14:12]
in_func7  input  1  bit 30 (R-type, shift-immediate)
in_rs1  input  5  bits [19:15]
in_rs2  input  5  bits [24:20]
in_rd  input  5  bits [11:7]
in_imm  input  32  immediate, full-width signed/byte-offset value
out_valid  output  1  out_inst/out_addr valid
out_ready  input  1  consumer accepts word
out_inst  output  32  encoded instruction
out_addr  output  32  byte address of out_inst
out_count  output  $clog2(DEPTH)+1  FIFO occupancy
err_illegal  output  1  one-cycle pulse: illegal in_fmt accepted
err_misalign  output  1  one-cycle pulse: B/J accepted with in_imm[0]=1

Behaviour:
- Reset (rst_n=0 at edge): FIFO emptied, out_count=0, out_valid=0, out_inst=0, addr counter=BASE_ADDR, err pulses=0. in_ready=1 during the first cycle after reset. Reset mid-stream discards all buffered words; in-flight handshakes in the reset cycle are ignored.
- Input handshake: accept when in_valid&&in_ready. in_ready = !full; no pass-through when full, even if a pop occurs the same cycle.
- Encoding, combinational on inputs, written to FIFO on accept. Bits [6:0]={in_opcode,2'b11} for all formats:
  R: {1'b0,in_func7,5'b0, rs2, rs1, func3, rd}
  I: {imm[11:0], rs1, func3, rd}. Exception: opcode 5'b00100 with func3 001/101 uses {1'b0,in_func7,5'b0, imm[4:0]} in [31:20].
  S: {imm[11:5], rs2, rs1, func3, imm[4:0]}
  B: {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11]}
  U: {imm[31:12], rd}
  J: {imm[20], imm[10:1], imm[11], imm[19:12], rd}
  Unused immediate bits are dropped silently.
- Illegal fmt (6/7): bundle is accepted (consumed, in_ready unaffected) but NOT enqueued; err_illegal=1 the next cycle only.
- B/J with imm[0]=1: word is encoded and enqueued normally; err_misalign=1 the next cycle only.
- Latency: a bundle accepted at edge N is visible at out_valid/out_inst from edge N (registered FIFO head); minimum 1 cycle input-to-output.
- Output: out_valid = !empty. out_inst/out_addr are held stable while out_valid&&!out_ready.
- On out_valid&&out_ready, pop, and addr counter += 4, wrapping modulo 2^32.
- Simultaneous push and pop when not full and not empty: occupancy unchanged, order preserved. Push into empty with no pop: out_count 0->1.
- When empty, out_inst holds its last value; consumers must ignore it.

Test Plan:
- Encoding vectors, one each, out_ready=1: addi x1,x0,5 (I, op 00100, f3 0, imm 5) -> 0x00500093. add x3,x1,x2 (R, op 01100) -> 0x002081B3; same with func7=1 -> 0x402081B3. srai x5,x5,3 -> 0x4032D293. lui x2,imm=0x12345000 -> 0x12345137. beq x1,x2,+8 (op 11000) -> 0x00208463. jal x1,+2048 (op 11011) -> 0x001000EF. Addresses 0,4,8,...
- Backpressure: out_ready=0, push 5 bundles with DEPTH=4 -> in_ready=0 after the 4th, out_count=4, 5th held; release out_ready -> the 5th is accepted after the first pop, order intact, out_inst stable while stalled.
- Errors: in_fmt=6 -> err_illegal pulses 1 cycle, out_count unchanged; B with imm=7 -> err_misalign pulses 1 cycle, word 0x00208363 (for beq x1,x2) enqueued.
- Address wrap: BASE_ADDR=0xFFFFFFF8, pop 3 words -> out_addr 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Reset mid-operation: 3 words buffered, rst_n=0 one cycle -> out_valid=0, out_count=0, next word tagged BASE_ADDR.
- Simultaneous push/pop at count=2 for 10 cycles -> out_count stays 2, stream order and addresses continuous.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I field-bundle encoder: packs opcode/func/register/immediate fields into
// 32-bit instruction words, buffers them in a FIFO and streams them out with byte addresses.
module inst_encoder #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [2:0]                 in_fmt,
   input  logic [4:0]                 in_opcode,
   input  logic [2:0]                 in_func3,
   input  logic                       in_func7,
   input  logic [4:0]                 in_rs1,
   input  logic [4:0]                 in_rs2,
   input  logic [4:0]                 in_rd,
   input  logic [31:0]                in_imm,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_inst,
   output logic [31:0]                out_addr,
   output logic [$clog2(DEPTH):0]     out_count,
   output logic                       err_illegal,
   output logic                       err_misalign
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, nxt_rd_ptr;
   logic [CW-1:0] count, nxt_count;
   logic [31:0]   addr_q, inst_q, nxt_head, enc;
   logic [24:0]   hi;
   logic          fmt_illegal, full, accept, push, pop, is_shift_imm;

   always_comb begin
      hi           = '0;
      fmt_illegal  = 1'b0;
      is_shift_imm = (in_opcode == 5'b00100) && ((in_func3 == 3'b001) || (in_func3 == 3'b101));
      case (in_fmt)
         FMT_R: hi = {1'b0, in_func7, 5'b0, in_rs2, in_rs1, in_func3, in_rd};
         FMT_I: begin
            if (is_shift_imm)
               hi = {1'b0, in_func7, 5'b0, in_imm[4:0], in_rs1, in_func3, in_rd};
            else
               hi = {in_imm[11:0], in_rs1, in_func3, in_rd};
         end
         FMT_S: hi = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0]};
         FMT_B: hi = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3, in_imm[4:1], in_imm[11]};
         FMT_U: hi = {in_imm[31:12], in_rd};
         FMT_J: hi = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd};
         default: fmt_illegal = 1'b1;
      endcase
      enc = {hi, in_opcode, 2'b11};
   end

   assign full      = (count == CW'(DEPTH));
   assign in_ready  = !full;
   assign out_valid = (count != '0);
   assign accept    = in_valid && in_ready;
   assign push      = accept && !fmt_illegal;
   assign pop       = out_valid && out_ready;

   // Head register is reloaded with whatever entry heads the FIFO after this edge;
   // a word pushed into a slot that becomes the head bypasses the array.
   always_comb begin
      nxt_rd_ptr = pop ? rd_ptr + AW'(1) : rd_ptr;
      nxt_count  = count + CW'(push) - CW'(pop);
      nxt_head   = (push && (wr_ptr == nxt_rd_ptr)) ? enc : mem[nxt_rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= enc;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         inst_q       <= '0;
         addr_q       <= BASE_ADDR;
         err_illegal  <= 1'b0;
         err_misalign <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         rd_ptr <= nxt_rd_ptr;
         count  <= nxt_count;
         if (nxt_count != '0)
            inst_q <= nxt_head;
         if (pop)
            addr_q <= addr_q + 32'd4;
         err_illegal  <= accept && fmt_illegal;
         err_misalign <= accept && ((in_fmt == FMT_B) || (in_fmt == FMT_J)) && in_imm[0];
      end
   end

   assign out_inst  = inst_q;
   assign out_addr  = addr_q;
   assign out_count = count;

endmodule
